// File: rtl/mcu_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding logic.
package mcu_pkg;

   localparam int unsigned WB_DEPTH_MAX = 7;
   localparam int unsigned REG_AW_MAX   = 8;
   localparam int unsigned FWD_SEL_W    = $clog2(WB_DEPTH_MAX + 1);

   localparam logic [FWD_SEL_W-1:0] FWD_RF = '0;

   // Addresses are stored zero-extended so one entry type serves any REG_AW.
   typedef struct packed {
      logic                  wr;
      logic [REG_AW_MAX-1:0] da;
      logic                  late;
   } sb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode-stage hazard detection: scoreboard of in-flight writers, stall/flush
// generation and operand bypass selection, with stall/flush event counters.
module hazard_fwd_unit
   import mcu_pkg::*;
#(
   parameter int unsigned REG_AW   = 3,
   parameter int unsigned WB_DEPTH = 2,
   parameter bit          FWD_EN   = 1'b1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 dec_valid,
   input  logic [REG_AW-1:0]    dec_aa,
   input  logic [REG_AW-1:0]    dec_ba,
   input  logic                 dec_use_a,
   input  logic                 dec_use_b,
   input  logic                 dec_rw,
   input  logic [REG_AW-1:0]    dec_da,
   input  logic                 dec_late,
   input  logic                 br_taken,
   output logic                 stall,
   output logic                 flush,
   output logic [FWD_SEL_W-1:0] fwd_a_sel,
   output logic [FWD_SEL_W-1:0] fwd_b_sel,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam int Depth = int'(WB_DEPTH);

   sb_entry_t             sb_q [1:WB_DEPTH];
   sb_entry_t             sb1_d;
   logic [REG_AW_MAX-1:0] aa_ext, ba_ext, da_ext;
   logic                  hit_a, hit_b, late_a, late_b;
   int                    k_a, k_b;
   logic                  need_a, need_b, hazard;

   assign aa_ext = REG_AW_MAX'(dec_aa);
   assign ba_ext = REG_AW_MAX'(dec_ba);
   assign da_ext = REG_AW_MAX'(dec_da);

   // Scan oldest to youngest so the youngest matching stage wins.
   always_comb begin
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      late_a = 1'b0;
      late_b = 1'b0;
      k_a    = 0;
      k_b    = 0;
      for (int k = Depth; k >= 1; k--) begin
         if (dec_valid && sb_q[k].wr) begin
            if (dec_use_a && (sb_q[k].da == aa_ext)) begin
               hit_a  = 1'b1;
               late_a = sb_q[k].late;
               k_a    = k;
            end
            if (dec_use_b && (sb_q[k].da == ba_ext)) begin
               hit_b  = 1'b1;
               late_b = sb_q[k].late;
               k_b    = k;
            end
         end
      end
   end

   // A late result is only usable once its producer sits in writeback.
   assign need_a = hit_a && (!FWD_EN || (late_a && (k_a < Depth)));
   assign need_b = hit_b && (!FWD_EN || (late_b && (k_b < Depth)));
   assign hazard = need_a || need_b;

   assign stall = !reset && !br_taken && hazard;
   assign flush = !reset && br_taken;

   assign fwd_a_sel = (!reset && FWD_EN && hit_a && !hazard) ? FWD_SEL_W'(k_a) : FWD_RF;
   assign fwd_b_sel = (!reset && FWD_EN && hit_b && !hazard) ? FWD_SEL_W'(k_b) : FWD_RF;

   always_comb begin
      sb1_d = '0;
      if (!stall && !flush) begin
         sb1_d.wr   = dec_valid & dec_rw;
         sb1_d.da   = da_ext;
         sb1_d.late = dec_late;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= Depth; k++) begin
            sb_q[k] <= '0;
         end
      end else begin
         sb_q[1] <= sb1_d;
         for (int k = 2; k <= Depth; k++) begin
            sb_q[k] <= sb_q[k-1];
         end
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (stall),
      .cnt  (stall_cnt)
   );

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_flush_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (flush),
      .cnt  (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench: default, stall-only and narrow-counter instances share one
// decode stimulus stream; each scenario task checks its own instance.
module tb_hazard_fwd_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       dec_valid, dec_use_a, dec_use_b, dec_rw, dec_late, br_taken;
   logic [2:0] dec_aa, dec_ba, dec_da;

   logic        stall_d, flush_d, stall_n, flush_n, stall_s, flush_s;
   logic [2:0]  fa_d, fb_d, fa_n, fb_n, fa_s, fb_s;
   logic [15:0] sc_d, fc_d, sc_n, fc_n;
   logic [3:0]  sc_s, fc_s;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_fwd_unit #(.REG_AW(3), .WB_DEPTH(2), .FWD_EN(1'b1), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_aa(dec_aa), .dec_ba(dec_ba),
      .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_rw(dec_rw), .dec_da(dec_da),
      .dec_late(dec_late), .br_taken(br_taken), .stall(stall_d), .flush(flush_d),
      .fwd_a_sel(fa_d), .fwd_b_sel(fb_d), .stall_cnt(sc_d), .flush_cnt(fc_d)
   );

   hazard_fwd_unit #(.REG_AW(3), .WB_DEPTH(2), .FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_aa(dec_aa), .dec_ba(dec_ba),
      .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_rw(dec_rw), .dec_da(dec_da),
      .dec_late(dec_late), .br_taken(br_taken), .stall(stall_n), .flush(flush_n),
      .fwd_a_sel(fa_n), .fwd_b_sel(fb_n), .stall_cnt(sc_n), .flush_cnt(fc_n)
   );

   hazard_fwd_unit #(.REG_AW(3), .WB_DEPTH(2), .FWD_EN(1'b1), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_aa(dec_aa), .dec_ba(dec_ba),
      .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_rw(dec_rw), .dec_da(dec_da),
      .dec_late(dec_late), .br_taken(br_taken), .stall(stall_s), .flush(flush_s),
      .fwd_a_sel(fa_s), .fwd_b_sel(fb_s), .stall_cnt(sc_s), .flush_cnt(fc_s)
   );

   task automatic drive(input logic v, input logic [2:0] aa, input logic ua,
                        input logic [2:0] ba, input logic ub, input logic rw,
                        input logic [2:0] da, input logic late, input logic br);
      dec_valid = v;  dec_aa = aa; dec_use_a = ua; dec_ba = ba; dec_use_b = ub;
      dec_rw    = rw; dec_da = da; dec_late  = late; br_taken = br;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
      #1;
      checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall_d); end
      checks++; if (flush_d !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0b exp=0", flush_d); end
      checks++; if (fa_d !== 3'd0) begin failures++; $display("FAIL rst_fwd_a got=%0d exp=0", fa_d); end
      checks++; if (fb_d !== 3'd0) begin failures++; $display("FAIL rst_fwd_b got=%0d exp=0", fb_d); end
      tick();
      checks++; if (sc_d !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", sc_d); end
      checks++; if (fc_d !== 16'd0) begin failures++; $display("FAIL rst_flush_cnt got=%0d exp=0", fc_d); end
      reset = 1'b0;
      idle();
      #1;
      checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL post_rst_stall got=%0b exp=0", stall_d); end
      checks++; if (flush_d !== 1'b0) begin failures++; $display("FAIL post_rst_flush got=%0b exp=0", flush_d); end
   endtask

   task automatic test_alu_b2b();
      do_reset();
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
      #1;
      checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL alu_prod_stall got=%0b exp=0", stall_d); end
      tick();
      drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      checks++; if (fa_d !== 3'd1) begin failures++; $display("FAIL alu_fwd_a got=%0d exp=1", fa_d); end
      checks++; if (fb_d !== 3'd0) begin failures++; $display("FAIL alu_fwd_b got=%0d exp=0", fb_d); end
      checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", stall_d); end
      tick();
      idle();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
      tick();
      drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL lu_stall1 got=%0b exp=1", stall_d); end
      checks++; if (fa_d !== 3'd0) begin failures++; $display("FAIL lu_fwd_a1 got=%0d exp=0", fa_d); end
      tick();
      checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL lu_stall2 got=%0b exp=0", stall_d); end
      checks++; if (fa_d !== 3'd2) begin failures++; $display("FAIL lu_fwd_a2 got=%0d exp=2", fa_d); end
      checks++; if (sc_d !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", sc_d); end
      tick();
      idle();
      #1;
      checks++; if (sc_d !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt_hold got=%0d exp=1", sc_d); end
   endtask

   task automatic test_no_fwd();
      do_reset();
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
      tick();
      drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      checks++; if (stall_n !== 1'b1) begin failures++; $display("FAIL nf_stall1 got=%0b exp=1", stall_n); end
      checks++; if (fa_n !== 3'd0) begin failures++; $display("FAIL nf_fwd_a1 got=%0d exp=0", fa_n); end
      checks++; if (fa_d !== 3'd1) begin failures++; $display("FAIL nf_ref_fwd_a got=%0d exp=1", fa_d); end
      tick();
      checks++; if (stall_n !== 1'b1) begin failures++; $display("FAIL nf_stall2 got=%0b exp=1", stall_n); end
      checks++; if (fa_n !== 3'd0) begin failures++; $display("FAIL nf_fwd_a2 got=%0d exp=0", fa_n); end
      tick();
      checks++; if (stall_n !== 1'b0) begin failures++; $display("FAIL nf_stall3 got=%0b exp=0", stall_n); end
      checks++; if (fa_n !== 3'd0) begin failures++; $display("FAIL nf_fwd_a3 got=%0d exp=0", fa_n); end
      checks++; if (sc_n !== 16'd2) begin failures++; $display("FAIL nf_stall_cnt got=%0d exp=2", sc_n); end
      tick();
      idle();
   endtask

   task automatic test_youngest();
      do_reset();
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
      tick();
      tick();
      drive(1'b1, 3'd4, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      checks++; if (fb_d !== 3'd1) begin failures++; $display("FAIL yw_fwd_b got=%0d exp=1", fb_d); end
      checks++; if (fa_d !== 3'd0) begin failures++; $display("FAIL yw_fwd_a_unused got=%0d exp=0", fa_d); end
      checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL yw_stall got=%0b exp=0", stall_d); end
      dec_valid = 1'b0;
      #1;
      checks++; if (fb_d !== 3'd0) begin failures++; $display("FAIL yw_invalid_fwd_b got=%0d exp=0", fb_d); end
      tick();
      idle();
   endtask

   task automatic test_branch_stall();
      do_reset();
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
      tick();
      drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
      #1;
      checks++; if (flush_d !== 1'b1) begin failures++; $display("FAIL br_flush got=%0b exp=1", flush_d); end
      checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL br_stall got=%0b exp=0", stall_d); end
      tick();
      drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      checks++; if (fa_d !== 3'd0) begin failures++; $display("FAIL br_bubble_fwd_a got=%0d exp=0", fa_d); end
      checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL br_after_stall got=%0b exp=0", stall_d); end
      checks++; if (flush_d !== 1'b0) begin failures++; $display("FAIL br_after_flush got=%0b exp=0", flush_d); end
      checks++; if (fc_d !== 16'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=1", fc_d); end
      checks++; if (sc_d !== 16'd0) begin failures++; $display("FAIL br_stall_cnt got=%0d exp=0", sc_d); end
      tick();
      idle();
   endtask

   // Self-dependent late load repeated: stalls on every odd cycle, 20 in 41 cycles.
   task automatic test_saturation();
      logic exp_stall;
      do_reset();
      drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
      for (int i = 0; i <= 40; i++) begin
         exp_stall = ((i % 2) == 1);
         #1;
         checks++;
         if (stall_s !== exp_stall) begin
            failures++;
            $display("FAIL sat_stall[%0d] got=%0b exp=%0b", i, stall_s, exp_stall);
         end
         tick();
      end
      #1;
      checks++; if (stall_s !== 1'b1) begin failures++; $display("FAIL sat_mid_stall got=%0b exp=1", stall_s); end
      checks++; if (sc_s !== 4'd15) begin failures++; $display("FAIL sat_stall_cnt got=%0d exp=15", sc_s); end
      reset = 1'b1;
      #1;
      checks++; if (stall_s !== 1'b0) begin failures++; $display("FAIL sat_rst_stall got=%0b exp=0", stall_s); end
      tick();
      reset = 1'b0;
      #1;
      checks++; if (stall_s !== 1'b0) begin failures++; $display("FAIL sat_post_rst_stall got=%0b exp=0", stall_s); end
      checks++; if (sc_s !== 4'd0) begin failures++; $display("FAIL sat_post_rst_scnt got=%0d exp=0", sc_s); end
      checks++; if (fc_s !== 4'd0) begin failures++; $display("FAIL sat_post_rst_fcnt got=%0d exp=0", fc_s); end
      tick();
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_alu_b2b();
      test_load_use();
      test_no_fwd();
      test_youngest();
      test_branch_stall();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL take parameter REG_AW, default 3, meaning register-address width.
REQ-002 The block SHALL take parameter WB_DEPTH, default 2, meaning stages from decode output to writeback (range 1..7).
REQ-003 The block SHALL take parameter FWD_EN, default 1, meaning 1 = bypass enabled, 0 = stall-only (legacy behaviour).
REQ-004 The block SHALL take parameter CNT_W, default 16, meaning statistics counter width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows (clock and reset first).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- dec_valid  in  1  decode stage holds a real instruction.
- dec_aa, dec_ba  in  REG_AW  source register addresses.
- dec_use_a, dec_use_b  in  1  operand A/B read from register file (not PC/constant).
- dec_rw  in  1  instruction writes a register.
- dec_da  in  REG_AW  destination address.
- dec_late  in  1  result is only available at writeback (memory/IO read).
- br_taken  in  1  branch/jump resolved taken in execute.
- stall  out  1  hold PC, IF/ID and the decode stage; issue a bubble.
- flush  out  1  squash IF/ID and the decode stage.
- fwd_a_sel, fwd_b_sel  out  3  0 = register file; k = result of scoreboard stage k.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

Function
REQ-006 The block SHALL hold a scoreboard sb[1..WB_DEPTH] of {wr, da, late}; sb[1] SHALL be execute and sb[WB_DEPTH] SHALL be writeback.
REQ-007 On each clock edge, sb[k] SHALL load sb[k-1] for k>1.
REQ-008 On each clock edge, sb[1] SHALL load {dec_valid&dec_rw, dec_da, dec_late} when stall=0 and flush=0, and a bubble (wr=0) otherwise.
REQ-009 An operand match SHALL require use=1, dec_valid=1, sb[k].wr=1 and sb[k].da equal to the source address; only the youngest match (smallest k) SHALL count.
REQ-010 With FWD_EN=0, any match on either operand SHALL assert stall.
REQ-011 With FWD_EN=1, a youngest match with late=1 and k<WB_DEPTH SHALL assert stall; every other match SHALL drive fwd_x_sel=k.
REQ-012 fwd_x_sel SHALL be 0 when there is no match, when stall=1, or when FWD_EN=0.
REQ-013 stall, flush and fwd_*_sel SHALL be combinational from the registered scoreboard and the current decode inputs, with zero-cycle latency.
REQ-014 flush SHALL equal br_taken; br_taken SHALL force stall=0 because the stalled instruction is squashed.
REQ-015 The register file is not write-through, so a writeback-stage match (k=WB_DEPTH) SHALL forward rather than read the register file.
REQ-016 stall_cnt SHALL increment on each cycle with stall=1 and flush_cnt on each cycle with flush=1; both SHALL saturate at all-ones and never wrap.
REQ-017 A load-use stall SHALL last exactly until the producer reaches WB_DEPTH, which is WB_DEPTH-k cycles for a producer at stage k.

Reset
REQ-018 reset=1 at a clock edge SHALL clear every sb[k].wr and da/late and set both counters to 0.
REQ-019 While reset=1, stall, flush and fwd_*_sel SHALL read 0 regardless of the other inputs.
REQ-020 Reset mid-stall SHALL drop the stall on the following cycle.

Structure
REQ-021 The scoreboard entry struct, the fwd-select encoding (FWD_RF=0) and the WB_DEPTH limit SHALL live in the shared package mcu_pkg.
REQ-022 One sub-module, sat_counter (CNT_W parameter, inc and reset inputs), SHALL be instantiated twice.

Verification
REQ-023 The bench SHALL cover ALU back-to-back: r3 written, then the next instruction reads r3 as A -> fwd_a_sel=1, stall=0.
REQ-024 The bench SHALL cover a load-use case with WB_DEPTH=2: a late write to r5 followed by a read of r5 -> stall=1 for 1 cycle, then fwd_a_sel=2, and stall_cnt=1.
REQ-025 The bench SHALL cover FWD_EN=0: a write to r2 followed by a read of r2 -> stall for 2 cycles, with fwd selects held at 0.
REQ-026 The bench SHALL cover youngest-wins: sb[1] and sb[2] both write r4 and decode reads r4 in B -> fwd_b_sel=1.
REQ-027 The bench SHALL cover branch during stall: a load-use stall with br_taken=1 in the same cycle -> flush=1, stall=0, sb[1] bubble, flush_cnt=1.
REQ-028 The bench SHALL cover saturation and reset: CNT_W=4 with 20 stall cycles -> stall_cnt=15; reset asserted mid-stall -> counters 0 and stall=0 on the next cycle.
